// File: rtl/taillight_pkg.sv
// Shared types, lamp patterns and state-sequencing helpers for the taillight controller.
package taillight_pkg;

    localparam int unsigned TICK_DIV_50MHZ = 12_500_000;

    localparam logic [2:0] PAT_OFF = 3'b000;
    localparam logic [2:0] PAT_1   = 3'b001;
    localparam logic [2:0] PAT_2   = 3'b011;
    localparam logic [2:0] PAT_3   = 3'b111;

    typedef enum logic [3:0] {
        IDLE,
        L1,
        L2,
        L3,
        LOFF,
        R1,
        R2,
        R3,
        ROFF,
        HON,
        HOFF
    } tl_state_t;

    typedef enum logic [1:0] {
        REQ_NONE,
        REQ_HAZ,
        REQ_LEFT,
        REQ_RIGHT
    } req_t;

    // Simultaneous left and right is treated as a hazard request.
    function automatic req_t decode_req(input logic i_left, input logic i_right,
                                        input logic i_hazard);
        req_t r;
        if (i_hazard || (i_left && i_right)) begin
            r = REQ_HAZ;
        end else if (i_left) begin
            r = REQ_LEFT;
        end else if (i_right) begin
            r = REQ_RIGHT;
        end else begin
            r = REQ_NONE;
        end
        return r;
    endfunction

    function automatic req_t seq_of(input tl_state_t s);
        req_t r;
        case (s)
            L1, L2, L3, LOFF: r = REQ_LEFT;
            R1, R2, R3, ROFF: r = REQ_RIGHT;
            HON, HOFF:        r = REQ_HAZ;
            default:          r = REQ_NONE;
        endcase
        return r;
    endfunction

    function automatic tl_state_t first_state(input req_t r);
        tl_state_t s;
        case (r)
            REQ_HAZ:   s = HON;
            REQ_LEFT:  s = L1;
            REQ_RIGHT: s = R1;
            default:   s = IDLE;
        endcase
        return s;
    endfunction

    function automatic tl_state_t advance(input tl_state_t s);
        tl_state_t n;
        case (s)
            L1:      n = L2;
            L2:      n = L3;
            L3:      n = LOFF;
            LOFF:    n = L1;
            R1:      n = R2;
            R2:      n = R3;
            R3:      n = ROFF;
            ROFF:    n = R1;
            HON:     n = HOFF;
            HOFF:    n = HON;
            default: n = IDLE;
        endcase
        return n;
    endfunction

    // Lamp pattern for the turning side; identical for left and right sequences.
    function automatic logic [2:0] turn_pat(input tl_state_t s);
        logic [2:0] p;
        case (s)
            L1, R1:  p = PAT_1;
            L2, R2:  p = PAT_2;
            L3, R3:  p = PAT_3;
            default: p = PAT_OFF;
        endcase
        return p;
    endfunction

endpackage

// File: rtl/taillight_seq_ctrl_tick_gen.sv
// Animation tick divider: step pulses for one cycle every TICK_DIV clocks, clr restarts the period.
module tick_gen
    import taillight_pkg::*;
#(
    parameter int unsigned TICK_DIV = TICK_DIV_50MHZ
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    output logic step
);

    localparam int CW = $clog2(TICK_DIV);
    localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

    logic [CW-1:0] r_cnt;
    logic          w_last;

    assign w_last = (r_cnt == LAST);
    assign step   = w_last;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (clr || w_last) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + CW'(1);
        end
    end

endmodule

// File: rtl/taillight_seq_ctrl.sv
// Taillight sequencer: arbitrates hazard/left/right requests, steps the Thunderbird pattern
// on animation ticks and overlays brake onto the registered lamp outputs.
//
//   state | meaning
//   IDLE  | no request; lamps off, or all on with brake
//   L1    | left 001
//   L2    | left 011
//   L3    | left 111
//   LOFF  | left 000
//   R1    | right 001
//   R2    | right 011
//   R3    | right 111
//   ROFF  | right 000
//   HON   | hazard, both sides 111
//   HOFF  | hazard, both sides 000
module taillight_seq_ctrl
    import taillight_pkg::*;
#(
    parameter int unsigned TICK_DIV = TICK_DIV_50MHZ
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       left,
    input  logic       right,
    input  logic       hazard,
    input  logic       brake,
    output logic [2:0] tl,
    output logic [2:0] tr,
    output logic       step
);

    tl_state_t  r_state;
    tl_state_t  w_state_nxt;
    req_t       w_req;
    logic       r_armed;
    logic       w_tick;
    logic       w_clr;
    logic [2:0] r_tl;
    logic [2:0] r_tr;
    logic [2:0] w_tl_nxt;
    logic [2:0] w_tr_nxt;

    assign w_req = decode_req(left, right, hazard);

    // Leaving IDLE restarts the tick period so the first advance is a full step later.
    assign w_clr = (r_state == IDLE) && r_armed && (w_req != REQ_NONE);

    tick_gen #(
        .TICK_DIV (TICK_DIV)
    ) u_tick_gen (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (w_clr),
        .step  (w_tick)
    );

    assign step = w_tick;
    assign tl   = r_tl;
    assign tr   = r_tr;

    always_comb begin
        w_state_nxt = r_state;
        if (r_state == IDLE) begin
            if (r_armed) begin
                w_state_nxt = first_state(w_req);
            end
        end else if (w_tick) begin
            if (w_req == seq_of(r_state)) begin
                w_state_nxt = advance(r_state);
            end else begin
                w_state_nxt = first_state(w_req);
            end
        end
    end

    // Brake lights the non-turning side, or both sides in IDLE; hazard ignores it.
    always_comb begin
        w_tl_nxt = PAT_OFF;
        w_tr_nxt = PAT_OFF;
        case (seq_of(w_state_nxt))
            REQ_HAZ: begin
                w_tl_nxt = (w_state_nxt == HON) ? PAT_3 : PAT_OFF;
                w_tr_nxt = (w_state_nxt == HON) ? PAT_3 : PAT_OFF;
            end
            REQ_LEFT: begin
                w_tl_nxt = turn_pat(w_state_nxt);
                w_tr_nxt = brake ? PAT_3 : PAT_OFF;
            end
            REQ_RIGHT: begin
                w_tl_nxt = brake ? PAT_3 : PAT_OFF;
                w_tr_nxt = turn_pat(w_state_nxt);
            end
            default: begin
                w_tl_nxt = brake ? PAT_3 : PAT_OFF;
                w_tr_nxt = brake ? PAT_3 : PAT_OFF;
            end
        endcase
    end

    // r_armed holds off request acceptance for the first edge after reset release.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_armed <= 1'b0;
            r_tl    <= PAT_OFF;
            r_tr    <= PAT_OFF;
        end else begin
            r_state <= w_state_nxt;
            r_armed <= 1'b1;
            r_tl    <= w_tl_nxt;
            r_tr    <= w_tr_nxt;
        end
    end

endmodule

// File: doc/taillight_seq_ctrl.md
# taillight_seq_ctrl

Sequencing controller for the rear taillight pair (three lamps per side, `tl[2:0]` left and `tr[2:0]` right). It arbitrates between hazard, brake, left-turn and right-turn requests from the switch inputs and steps a Thunderbird-style pattern at a divided rate from the 50 MHz board clock. It drives the LED outputs directly as registered signals and sits between the switch/debounce logic and the LEDR pins.

## Interface
- `TICK_DIV`, default 12_500_000: clk cycles per animation step (4 Hz at 50 MHz). Legal range is 2 or more. Benches use 4.
- `clk`  in  1  board clock (CLOCK_50)
- `rst_n`  in  1  reset, asynchronous, active-low
- `left`  in  1  left-turn request, level-sensitive, synchronous to clk
- `right`  in  1  right-turn request, level-sensitive
- `hazard`  in  1  error/hazard request, level-sensitive
- `brake`  in  1  brake request, level-sensitive
- `tl`  out  3  left lamps; bit 0 is innermost; registered
- `tr`  out  3  right lamps; bit 0 is innermost; registered
- `step`  out  1  one-cycle pulse on each animation tick (debug/LED)

## Operation
- **Effective request:** `haz_req = hazard | (left & right)`. Priority is haz_req, then left, then right, then none.
- **FSM states:** IDLE, L1, L2, L3, LOFF, R1, R2, R3, ROFF, HON, HOFF.
- **Turn patterns:**
  - L1/L2/L3/LOFF drive tl = 001/011/111/000.
  - R1..ROFF drive tr the same way.
  - The side that is not turning is 000.
- **Hazard patterns:** HON drives tl = tr = 111. HOFF drives both to 000.
- **From IDLE:** the FSM leaves on any request at the next clk, without waiting for a tick. It goes to HON, L1 or R1 by priority, and the tick counter clears.
- **Non-IDLE transitions:** these happen only on a tick. At each tick the effective request is re-evaluated.
  - Same request as the current sequence: advance L1→L2→L3→LOFF→L1 (likewise for R), or HON↔HOFF.
  - Different request: jump to the first state of the new sequence (HON, L1 or R1).
  - No request: go to IDLE.
- **Brake overlay** (applied when computing the outputs, not in the FSM):
  - IDLE gives tl = tr = 111.
  - During a left sequence, tr = 111. During a right sequence, tl = 111.
  - Brake is ignored during HON/HOFF.
- **Tick generator:** counter 0..TICK_DIV-1. `step` is high when the count equals TICK_DIV-1, then the counter wraps to 0. The counter is also forced to 0 on IDLE exit.

## Timing
- **Reset:** state = IDLE, counter = 0, tl = tr = 000, step = 0. Asynchronous assertion clears these immediately, including mid-sequence. The first request is accepted on the second clk edge after rst_n rises.
- **Output latency:** tl/tr are registered from the next state and the brake value sampled on the same edge.
  - A request seen in IDLE at edge N produces the L1/R1/HON pattern at edge N+1.
  - A brake change appears at the next edge.
- **Step period:** after entering a sequence at edge N, each subsequent step occurs every TICK_DIV cycles. The first advance is at edge N+TICK_DIV.
- **Glitches:** requests that toggle between ticks and are not IDLE exits are not captured. Only the level present at the tick edge matters.
- **Simultaneous left+right:** treated as hazard, including at IDLE exit.
- **Release mid-step:** a request released mid-step holds the current pattern until the tick, then goes to IDLE (000, or 111/111 if brake is asserted).

## Structure
- **Package `taillight_pkg`:**
  - State enum `tl_state_t`.
  - Pattern constants `PAT_OFF` = 000, `PAT_1` = 001, `PAT_2` = 011, `PAT_3` = 111.
  - Default `TICK_DIV_50MHZ`.
- **Sub-module `tick_gen`:** parameter TICK_DIV; inputs clk, rst_n, clr; output step. Counter width is `$clog2(TICK_DIV)`.
- **Top level:** the FSM and the output/brake overlay register.

## Test plan
All scenarios use TICK_DIV = 4.
- **Left turn:** reset, then hold `left`. tl sequence is 001 one cycle after the request, then 011, 111, 000, 001 at 4-cycle spacing. tr stays 000.
- **Right turn with brake:** hold `right` and `brake`. tr steps 001/011/111/000 while tl holds 111. Dropping `brake` gives tl = 000 on the next edge.
- **Hazard:** assert `hazard`, or `left` and `right` together. Both sides alternate 111/000 every 4 cycles, and `brake` has no effect.
- **Switching sides:** in state L2, switch `left` to `right` just before a tick. At the tick, tr = 001 and tl = 000.
- **Release and idle brake:** release `left` in L3, with `brake` high. At the next tick the outputs go to 111/111 (IDLE with brake). With brake low they go to 000/000.
- **Reset mid-sequence:** pull rst_n low in R2 between clock edges. tl/tr are 000 immediately. After release, a `right` request restarts at R1 (001).
